mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 176 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and signed divide (restoring on magnitudes).
// One iteration per clock; results are registered into hi/lo on the completion edge.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             qm1_q, qm1_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign m_ext = {m_q[WIDTH-1], m_q};
    // Magnitude of the most-negative value is 2^(WIDTH-1), which still fits unsigned.
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_d       = q_q;
        m_d       = m_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        div0_d    = 1'b0;
        booth_sum = acc_q;
        div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, m_q});

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    cnt_d = '0;
                    qm1_d = 1'b0;
                    acc_d = '0;
                    if (!op) begin
                        state_d = S_MULT;
                        q_d     = b;
                        m_d     = a;
                    end else if (b == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        div0_d  = 1'b1;
                    end else begin
                        state_d   = S_DIV;
                        q_d       = a_mag;
                        m_d       = b_mag;
                        neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
                        neg_rem_d = a[WIDTH-1];
                    end
                end
            end
            S_MULT: begin
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    hi_d    = acc_q[WIDTH-1:0];
                    lo_d    = q_q;
                end else begin
                    case ({q_q[0], qm1_q})
                        2'b01:   booth_sum = acc_q + m_ext;
                        2'b10:   booth_sum = acc_q - m_ext;
                        default: booth_sum = acc_q;
                    endcase
                    // Arithmetic right shift of the {acc, q, q-1} triple.
                    acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                    q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
                    qm1_d = q_q[0];
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DIV: begin
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    lo_d    = neg_quo_q ? -q_q : q_q;
                    hi_d    = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end else begin
                    if (div_ge) begin
                        acc_d = div_shift - {1'b0, m_q};
                        q_d   = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift;
                        q_d   = {q_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_MULT) || (state_d == S_DIV);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            q_q       <= '0;
            m_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            m_q       <= m_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            div0_q    <= div0_d;
            busy_q    <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed literal cases plus randomized traffic against a
// transaction-level model that knows only latency and the arithmetic results.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference arithmetic ----------------
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
    endfunction

    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, qv, rv;
        logic [63:0] qb, rb;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        qv = sx / sy;
        rv = sx % sy;
        qb = qv;
        rb = rv;
        return {rb[W-1:0], qb[W-1:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_busy = 0;
    int           m_rem  = 0;
    bit           m_done = 0;
    bit           m_div0 = 0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic [2*W-1:0] m_pend = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0;
            m_rem  = 0;
            m_done = 0;
            m_div0 = 0;
            m_hi   = '0;
            m_lo   = '0;
        end else begin
            m_done = 0;
            m_div0 = 0;
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    {m_hi, m_lo} = m_pend;
                end
            end else if (start) begin
                if (!op) begin
                    m_pend = ref_mul(a, b);
                    m_busy = 1;
                    m_rem  = W + 1;
                end else if (b == '0) begin
                    m_done = 1;
                    m_div0 = 1;
                end else begin
                    m_pend = ref_div(a, b);
                    m_busy = 1;
                    m_rem  = W + 1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("div0", 64'(div0), 64'(m_div0));
            chk("hi",   64'(hi),   64'(m_hi));
            chk("lo",   64'(lo),   64'(m_lo));
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge just after the accepting edge,
    // with operands scrambled to show they are not re-read while busy.
    task automatic drive(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 1'($urandom_range(0, 1));
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int n_done;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("reset_hi", 64'(hi), 64'h0);
        chk("reset_lo", 64'(lo), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        reset = 1'b0;
        @(negedge clk);

        // model pins
        chk("ref_mul_7x-3", ref_mul(32'd7, 32'hFFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("ref_div_-7/2", ref_div(32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("ref_div_ovf", ref_div(32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        // 7 * -3
        drive(1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_done(lat);
        chk("mul1_lat", 64'(lat), 64'd33);
        chk("mul1_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mul1_lo", 64'(lo), 64'hFFFF_FFEB);
        chk("mul1_div0", 64'(div0), 64'h0);

        // min * min, then divide back-to-back in the done cycle
        drive(1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(lat);
        chk("mul2_hi", 64'(hi), 64'h4000_0000);
        chk("mul2_lo", 64'(lo), 64'h0);
        drive(1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("b2b_busy", 64'(busy), 64'h1);
        wait_done(lat);
        chk("div1_lat", 64'(lat), 64'd33);
        chk("div1_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div1_hi", 64'(hi), 64'hFFFF_FFFF);

        // divide by zero: immediate done, results untouched, never busy
        @(negedge clk);
        drive(1'b1, 32'd5, 32'd0);
        wait_done(lat);
        chk("dz_lat", 64'(lat), 64'd0);
        chk("dz_div0", 64'(div0), 64'h1);
        chk("dz_busy", 64'(busy), 64'h0);
        chk("dz_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("dz_lo", 64'(lo), 64'hFFFF_FFFD);
        @(negedge clk);
        chk("dz_busy2", 64'(busy), 64'h0);
        chk("dz_div0_clr", 64'(div0), 64'h0);

        // divide overflow wraps
        drive(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        chk("ovf_lo", 64'(lo), 64'h8000_0000);
        chk("ovf_hi", 64'(hi), 64'h0);
        chk("ovf_div0", 64'(div0), 64'h0);

        // ignored start while busy, then reset mid-operation
        @(negedge clk);
        drive(1'b0, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        chk("rst_no_done", 64'(n_done), 64'h0);
        drive(1'b0, 32'd3, 32'd4);
        wait_done(lat);
        chk("mul3_lat", 64'(lat), 64'd33);
        chk("mul3_lo", 64'(lo), 64'd12);
        chk("mul3_hi", 64'(hi), 64'h0);

        // reset wins over a simultaneous start
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("rst_pri_busy", 64'(busy), 64'h0);
        @(negedge clk);
        chk("rst_pri_busy2", 64'(busy), 64'h0);

        // randomized traffic, including back-to-back, ignored starts and rare resets
        for (int i = 0; i < 6000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            start = ($urandom_range(0, 3) == 0);
            op    = 1'($urandom_range(0, 1));
            a     = pick();
            b     = pick();
            @(negedge clk);
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
